// File: rtl/dense_layer_engine.sv
// Fully-connected layer engine acting as an Avalon-MM master.
// It streams packed signed weights and activations from SDRAM and accumulates
// one dot product per output node. The result is saturated to 16 bits, passed
// through an optional ReLU, and written to OUT_BASE + 2*node.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   ready, act_mode     : start request (level), lane mode (0 binary, 1 multiply)
//   waitrequest, readdatavalid, readdata : Avalon slave responses
//   chipselect, byteenable, read_n, write_n, address, writedata : Avalon master
//   done, busy, nodes_done, toHexLed : status ({8'h0, nodes_done, 4'h0, state})
module dense_layer_engine #(
  parameter int unsigned N_IN     = 784,
  parameter int unsigned N_OUT    = 200,
  parameter int unsigned WBITS    = 4,
  parameter int unsigned IN_BASE  = 300000,
  parameter int unsigned W_BASE   = 800,
  parameter int unsigned OUT_BASE = 400000,
  parameter int unsigned ACC_W    = 24,
  parameter bit          RELU_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ready,
  input  logic        act_mode,
  input  logic        waitrequest,
  input  logic        readdatavalid,
  input  logic [15:0] readdata,
  output logic        chipselect,
  output logic [1:0]  byteenable,
  output logic        read_n,
  output logic        write_n,
  output logic [31:0] address,
  output logic [15:0] writedata,
  output logic        done,
  output logic        busy,
  output logic [15:0] nodes_done,
  output logic [31:0] toHexLed
);

  localparam int unsigned WPACK = 16 / WBITS;
  localparam int unsigned WORDS = N_IN / WPACK;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_RD_W = 4'd1, S_WT_W = 4'd2, S_RD_X = 4'd3, S_WT_X = 4'd4,
    S_MAC  = 4'd5, S_WR   = 4'd6, S_NEXT = 4'd7, S_DONE = 4'd8
  } state_t;

  state_t                   r_state;
  logic                     r_mode;
  logic [31:0]              r_w_idx;
  logic [31:0]              r_x_idx;
  logic [15:0]              r_node;
  logic signed [ACC_W-1:0]  r_acc;
  logic [15:0]              r_weight;
  logic [15:0]              r_act;
  logic                     r_read_n;
  logic                     r_write_n;
  logic [31:0]              r_address;
  logic [15:0]              r_writedata;
  logic                     r_done;
  logic                     r_busy;

  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_wl;
  logic signed [ACC_W-1:0]  w_xl;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic [15:0]              w_result;

  // Lane-wise contributions of the current word pair, then saturate/ReLU.
  always_comb begin
    w_sum = '0;
    w_wl  = '0;
    w_xl  = '0;
    for (int k = 0; k < int'(WPACK); k++) begin
      w_wl = {{(ACC_W-WBITS){r_weight[k*WBITS+WBITS-1]}}, r_weight[k*WBITS +: WBITS]};
      w_xl = {{(ACC_W-WBITS){r_act[k*WBITS+WBITS-1]}}, r_act[k*WBITS +: WBITS]};
      if (r_mode) begin
        w_sum = w_sum + w_wl * w_xl;
      end else if (r_act[k*WBITS]) begin
        w_sum = w_sum + w_wl;
      end
    end
    w_acc_next = r_acc + w_sum;
    if (RELU_EN && w_acc_next[ACC_W-1]) begin
      w_result = 16'h0000;
    end else if (w_acc_next > SAT_MAX) begin
      w_result = 16'h7FFF;
    end else if (w_acc_next < SAT_MIN) begin
      w_result = 16'h8000;
    end else begin
      w_result = w_acc_next[15:0];
    end
  end

  // Sequencer: bus strobes and address are set on entry to each bus state and
  // held until the slave drops waitrequest.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_w_idx     <= '0;
      r_x_idx     <= '0;
      r_node      <= '0;
      r_acc       <= '0;
      r_weight    <= '0;
      r_act       <= '0;
      r_read_n    <= 1'b1;
      r_write_n   <= 1'b1;
      r_address   <= '0;
      r_writedata <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_w_idx <= '0;
          r_x_idx <= '0;
          r_node  <= '0;
          r_acc   <= '0;
          if (ready) begin
            r_mode    <= act_mode;
            r_read_n  <= 1'b0;
            r_address <= 32'(W_BASE);
            r_busy    <= 1'b1;
            r_state   <= S_RD_W;
          end
        end
        S_RD_W: begin
          if (!waitrequest) begin
            r_read_n <= 1'b1;
            r_state  <= S_WT_W;
          end
        end
        S_WT_W: begin
          if (readdatavalid) begin
            r_weight  <= readdata;
            r_w_idx   <= r_w_idx + 32'd1;
            r_read_n  <= 1'b0;
            r_address <= 32'(IN_BASE) + (r_x_idx << 1);
            r_state   <= S_RD_X;
          end
        end
        S_RD_X: begin
          if (!waitrequest) begin
            r_read_n <= 1'b1;
            r_state  <= S_WT_X;
          end
        end
        S_WT_X: begin
          if (readdatavalid) begin
            r_act   <= readdata;
            r_x_idx <= r_x_idx + 32'd1;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= w_acc_next;
          if (r_x_idx < WORDS) begin
            r_read_n  <= 1'b0;
            r_address <= 32'(W_BASE) + (r_w_idx << 1);
            r_state   <= S_RD_W;
          end else begin
            // Result is captured here so writedata is stable throughout WR.
            r_writedata <= w_result;
            r_write_n   <= 1'b0;
            r_address   <= 32'(OUT_BASE) + 32'({r_node, 1'b0});
            r_state     <= S_WR;
          end
        end
        S_WR: begin
          if (!waitrequest) begin
            r_write_n <= 1'b1;
            r_node    <= r_node + 16'd1;
            r_state   <= S_NEXT;
          end
        end
        S_NEXT: begin
          r_acc   <= '0;
          r_x_idx <= '0;
          if (r_node < 16'(N_OUT)) begin
            r_read_n  <= 1'b0;
            r_address <= 32'(W_BASE) + (r_w_idx << 1);
            r_state   <= S_RD_W;
          end else begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // No auto-restart: a new run needs ready to drop first.
          if (!ready) begin
            r_done  <= 1'b0;
            r_node  <= '0;
            r_w_idx <= '0;
            r_x_idx <= '0;
            r_acc   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign chipselect = 1'b1;
  assign byteenable = 2'b11;
  assign read_n     = r_read_n;
  assign write_n    = r_write_n;
  assign address    = r_address;
  assign writedata  = r_writedata;
  assign done       = r_done;
  assign busy       = r_busy;
  assign nodes_done = r_node;
  assign toHexLed   = {8'h00, r_node, 4'h0, r_state};

endmodule

// File: tb/tb_dense_layer_engine.sv
// Bench for dense_layer_engine: three instances (WBITS=4 with and without
// ReLU, WBITS=16 multiply with a wide accumulator) share a randomly stalling
// SDRAM slave model. Expected writes are queued when memory is loaded and
// matched against the writes the slave accepts.
module tb_dense_layer_engine;

  localparam int W_BASE   = 800;
  localparam int IN_BASE  = 300000;
  localparam int OUT_BASE = 400000;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        rdy   [3];
  logic        mode  [3];
  logic        wreq  [3];
  logic        rdv   [3];
  logic [15:0] rdata [3];
  logic        cs    [3];
  logic [1:0]  be    [3];
  logic        rd_n  [3];
  logic        wr_n  [3];
  logic [31:0] addr  [3];
  logic [15:0] wdata [3];
  logic        dn    [3];
  logic        bsy   [3];
  logic [15:0] nd    [3];
  logic [31:0] hex   [3];

  dense_layer_engine #(.N_IN(8), .N_OUT(2), .WBITS(4), .ACC_W(24), .RELU_EN(1'b1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .ready(rdy[0]), .act_mode(mode[0]),
    .waitrequest(wreq[0]), .readdatavalid(rdv[0]), .readdata(rdata[0]),
    .chipselect(cs[0]), .byteenable(be[0]), .read_n(rd_n[0]), .write_n(wr_n[0]),
    .address(addr[0]), .writedata(wdata[0]), .done(dn[0]), .busy(bsy[0]),
    .nodes_done(nd[0]), .toHexLed(hex[0]));

  dense_layer_engine #(.N_IN(8), .N_OUT(2), .WBITS(4), .ACC_W(24), .RELU_EN(1'b0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .ready(rdy[1]), .act_mode(mode[1]),
    .waitrequest(wreq[1]), .readdatavalid(rdv[1]), .readdata(rdata[1]),
    .chipselect(cs[1]), .byteenable(be[1]), .read_n(rd_n[1]), .write_n(wr_n[1]),
    .address(addr[1]), .writedata(wdata[1]), .done(dn[1]), .busy(bsy[1]),
    .nodes_done(nd[1]), .toHexLed(hex[1]));

  dense_layer_engine #(.N_IN(4), .N_OUT(2), .WBITS(16), .ACC_W(40), .RELU_EN(1'b0)) u_dut_c (
    .clk(clk), .reset_n(reset_n), .ready(rdy[2]), .act_mode(mode[2]),
    .waitrequest(wreq[2]), .readdatavalid(rdv[2]), .readdata(rdata[2]),
    .chipselect(cs[2]), .byteenable(be[2]), .read_n(rd_n[2]), .write_n(wr_n[2]),
    .address(addr[2]), .writedata(wdata[2]), .done(dn[2]), .busy(bsy[2]),
    .nodes_done(nd[2]), .toHexLed(hex[2]));

  // Per-instance geometry
  function automatic int wb(input int i);   return (i == 2) ? 16 : 4; endfunction
  function automatic int nin(input int i);  return (i == 2) ? 4 : 8;  endfunction
  function automatic bit relu(input int i); return (i == 0);          endfunction
  function automatic int nx(input int i);   return nin(i) / (16 / wb(i)); endfunction
  function automatic int key(input int i, input int a); return i * 1048576 + a; endfunction

  typedef struct packed {
    logic [7:0]  inst;
    logic [31:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct packed {
    logic [1:0]        inst;
    logic              m;
    logic [7:0][15:0]  w;
    logic [3:0][15:0]  x;
    logic [1:0][15:0]  e;
  } vec_t;

  logic [15:0] mem [int];
  wr_t exp_q [$];
  wr_t got_q [$];
  int  got_ptr = 0;
  int  n_vec = 0;
  int  n_err = 0;

  bit          hold_en = 1'b0;
  logic [31:0] hold_addr = '0;

  // Slave-side state
  bit          in_txn [3];
  bit          is_wr  [3];
  int          stall  [3];
  logic [31:0] t_addr [3];
  logic [15:0] t_data [3];
  bit          rd_pend[3];
  int          rd_lat [3];
  logic [15:0] rd_val [3];
  int          rd_cnt [3];
  int          wr_cnt [3];
  int          bad_cnt[3];

  // Avalon slave: random waitrequest stalls, random read latency, stray
  // readdatavalid pulses while no read is pending, stability tracking.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) begin
        in_txn[i] = 1'b0;
        rd_pend[i] = 1'b0;
        wreq[i] = 1'b1;
        rdv[i] = 1'b0;
        rdata[i] = 16'h0;
      end else begin
        rdv[i] = 1'b0;
        if (rd_pend[i]) begin
          if (rd_lat[i] <= 1) begin
            rdv[i] = 1'b1;
            rdata[i] = rd_val[i];
            rd_pend[i] = 1'b0;
          end else begin
            rd_lat[i] = rd_lat[i] - 1;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          rdv[i] = 1'b1;
          rdata[i] = 16'($urandom);
        end
        if (in_txn[i]) begin
          if (addr[i] != t_addr[i]) bad_cnt[i]++;
          if (is_wr[i] && (wr_n[i] != 1'b0 || rd_n[i] != 1'b1 || wdata[i] != t_data[i])) bad_cnt[i]++;
          if (!is_wr[i] && (rd_n[i] != 1'b0 || wr_n[i] != 1'b1)) bad_cnt[i]++;
        end else if (rd_n[i] == 1'b0 || wr_n[i] == 1'b0) begin
          in_txn[i] = 1'b1;
          is_wr[i] = (wr_n[i] == 1'b0);
          t_addr[i] = addr[i];
          t_data[i] = wdata[i];
          stall[i] = int'($urandom_range(0, 5));
        end
        if (in_txn[i]) begin
          if (is_wr[i] && hold_en && t_addr[i] == hold_addr) begin
            wreq[i] = 1'b1;
          end else if (stall[i] > 0) begin
            wreq[i] = 1'b1;
            stall[i] = stall[i] - 1;
          end else begin
            wreq[i] = 1'b0;
            in_txn[i] = 1'b0;
            if (is_wr[i]) begin
              wr_cnt[i]++;
              got_q.push_back('{inst: 8'(i), addr: t_addr[i], data: t_data[i]});
            end else begin
              rd_cnt[i]++;
              rd_pend[i] = 1'b1;
              rd_lat[i] = int'($urandom_range(1, 8));
              rd_val[i] = mem.exists(key(i, int'(t_addr[i]))) ? mem[key(i, int'(t_addr[i]))] : 16'h0;
            end
          end
        end else begin
          wreq[i] = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Compare every newly accepted write against the scoreboard head.
  task automatic drain();
    wr_t e;
    while (got_ptr < got_q.size()) begin
      if (exp_q.size() == 0) begin
        chk("write_extra", 64'(got_q[got_ptr]), 64'h0);
      end else begin
        e = exp_q.pop_front();
        chk("write", 64'(got_q[got_ptr]), 64'(e));
      end
      got_ptr++;
    end
  endtask

  // Golden result of one node computed from the memory image.
  function automatic logic [15:0] model(input int i, input bit m, input int n);
    longint acc = 0;
    int wpk = 16 / wb(i);
    longint wl, xl, xraw, lim;
    logic [15:0] wv, xv;
    for (int j = 0; j < nx(i); j++) begin
      wv = mem[key(i, W_BASE + 2 * (n * nx(i) + j))];
      xv = mem[key(i, IN_BASE + 2 * j)];
      for (int k = 0; k < wpk; k++) begin
        lim  = longint'(1) << wb(i);
        wl   = (longint'(wv) >> (wb(i) * k)) % lim;
        xraw = (longint'(xv) >> (wb(i) * k)) % lim;
        if (wl >= lim / 2) wl = wl - lim;
        xl = (xraw >= lim / 2) ? xraw - lim : xraw;
        if (m) acc += wl * xl;
        else if (xraw % 2 == 1) acc += wl;
      end
    end
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    if (relu(i) && acc < 0) acc = 0;
    return 16'(acc);
  endfunction

  task automatic load_tbl(input vec_t v);
    int i = int'(v.inst);
    for (int j = 0; j < 2 * nx(i); j++) mem[key(i, W_BASE + 2 * j)] = v.w[j];
    for (int j = 0; j < nx(i); j++) mem[key(i, IN_BASE + 2 * j)] = v.x[j];
    for (int n = 0; n < 2; n++)
      exp_q.push_back('{inst: 8'(i), addr: 32'(OUT_BASE + 2 * n), data: v.e[n]});
  endtask

  task automatic run(input int i, input bit m, input bit hold_rdy);
    int r0 = rd_cnt[i];
    int w0 = wr_cnt[i];
    int b0 = bad_cnt[i];
    int cyc = 0;
    @(negedge clk);
    mode[i] = m;
    rdy[i] = 1'b1;
    @(negedge clk);
    if (!hold_rdy) rdy[i] = 1'b0;
    while (dn[i] !== 1'b1 && cyc < 4000) begin
      @(negedge clk);
      drain();
      cyc++;
    end
    drain();
    chk("done_seen", 64'(dn[i]), 64'h1);
    chk("nodes_done", 64'(nd[i]), 64'd2);
    chk("read_count", 64'(rd_cnt[i] - r0), 64'(4 * nx(i)));
    chk("write_count", 64'(wr_cnt[i] - w0), 64'd2);
    chk("bus_stable", 64'(bad_cnt[i] - b0), 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

  vec_t tbl [3];

  initial begin
    int cyc;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rdy[i] = 1'b0;
      mode[i] = 1'b0;
    end
    tbl[0] = '{inst: 2'd0, m: 1'b0,
               w: {16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF, 16'h4444, 16'h123F},
               x: {16'h0, 16'h0, 16'h0000, 16'h1011}, e: {16'h0000, 16'h0003}};
    tbl[1] = '{inst: 2'd1, m: 1'b0,
               w: {16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'hFFFF, 16'h4444, 16'h123F},
               x: {16'h0, 16'h0, 16'h0000, 16'h1011}, e: {16'hFFFD, 16'h0003}};
    tbl[2] = '{inst: 2'd2, m: 1'b1,
               w: {16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF},
               x: {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, e: {16'h8000, 16'h7FFF}};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_chipselect", 64'(cs[i]), 64'h1);
      chk("rst_byteenable", 64'(be[i]), 64'h3);
      chk("rst_state", 64'(hex[i]), 64'h0);
    end
    chk("rst_read_n", 64'(rd_n[0]), 64'h1);
    chk("rst_write_n", 64'(wr_n[0]), 64'h1);
    chk("rst_address", 64'(addr[0]), 64'h0);
    chk("rst_writedata", 64'(wdata[0]), 64'h0);
    chk("rst_done_busy", 64'({dn[0], bsy[0]}), 64'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed table: binary with/without ReLU, saturating 16-bit multiply
    for (int t = 0; t < 3; t++) begin
      load_tbl(tbl[t]);
      run(int'(tbl[t].inst), tbl[t].m, 1'b0);
    end

    // Random data on every instance, both modes
    for (int r = 0; r < 6; r++) begin
      int i = r % 3;
      bit m = 1'($urandom_range(0, 1));
      for (int j = 0; j < 2 * nx(i); j++) mem[key(i, W_BASE + 2 * j)] = 16'($urandom);
      for (int j = 0; j < nx(i); j++) mem[key(i, IN_BASE + 2 * j)] = 16'($urandom);
      for (int n = 0; n < 2; n++)
        exp_q.push_back('{inst: 8'(i), addr: 32'(OUT_BASE + 2 * n), data: model(i, m, n)});
      run(i, m, 1'b0);
    end

    // Reset while the node-1 write is stalled, then a clean rerun
    load_tbl(tbl[0]);
    hold_addr = 32'(OUT_BASE + 2);
    hold_en = 1'b1;
    @(negedge clk);
    mode[0] = 1'b0;
    rdy[0] = 1'b1;
    @(negedge clk);
    rdy[0] = 1'b0;
    cyc = 0;
    while (!(hex[0][3:0] == 4'd6 && nd[0] == 16'd1) && cyc < 4000) begin
      @(negedge clk);
      drain();
      cyc++;
    end
    chk("reach_wr_node1", 64'({hex[0][3:0], nd[0]}), 64'h60001);
    repeat (3) @(negedge clk);
    drain();
    chk("busy_in_wr", 64'(bsy[0]), 64'h1);
    chk("held_wr_n", 64'(wr_n[0]), 64'h0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_read_n", 64'(rd_n[0]), 64'h1);
    chk("async_write_n", 64'(wr_n[0]), 64'h1);
    chk("async_address", 64'(addr[0]), 64'h0);
    chk("async_writedata", 64'(wdata[0]), 64'h0);
    chk("async_status", 64'({dn[0], bsy[0], nd[0]}), 64'h0);
    chk("async_state", 64'(hex[0]), 64'h0);
    chk("sb_pending", 64'(exp_q.size()), 64'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    hold_en = 1'b0;
    load_tbl(tbl[0]);
    run(0, 1'b0, 1'b0);

    // ready held high keeps DONE; dropping it returns to IDLE next cycle
    load_tbl(tbl[1]);
    run(1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("hold_done", 64'(dn[1]), 64'h1);
    chk("hold_state", 64'(hex[1][3:0]), 64'h8);
    rdy[1] = 1'b0;
    @(negedge clk);
    chk("exit_state", 64'(hex[1][3:0]), 64'h0);
    chk("exit_status", 64'({dn[1], bsy[1], nd[1]}), 64'h0);
    repeat (4) @(negedge clk);
    chk("no_restart_busy", 64'(bsy[1]), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
